// File: rtl/gate_sweep_checker.sv
// Sweeps A/B over 00,01,10,11 for PASSES rounds and scores y_bus against the ideal gate truth table.
// Optional macro GATE_CHECK_STOP_ON_FAIL_EN: end the run at the first mismatching vector, leaving A/B on it.
module gate_sweep_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             A,
  output logic             B,
  input  logic [6:0]       y_bus,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [6:0]       fail_mask
);

  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PCW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int SW  = ERR_W + 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [SCW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [PCW-1:0]   pass_cnt_q, pass_cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [6:0]       fail_q, fail_d;

  logic [6:0]    expected;
  logic [6:0]    mism;
  logic [2:0]    mism_cnt;
  logic [SW-1:0] err_sum;
  logic [SW-1:0] err_max;
  logic          last_vec;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= 2'b00;
      settle_cnt_q <= '0;
      pass_cnt_q   <= '0;
      err_q        <= '0;
      fail_q       <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      settle_cnt_q <= settle_cnt_d;
      pass_cnt_q   <= pass_cnt_d;
      err_q        <= err_d;
      fail_q       <= fail_d;
    end
  end

  // Golden response for the vector currently driven, bit order {xnor,xor,nor,nand,or,and,not}.
  always_comb begin
    expected = {~(idx_q[1] ^ idx_q[0]), idx_q[1] ^ idx_q[0], ~(idx_q[1] | idx_q[0]),
                ~(idx_q[1] & idx_q[0]), idx_q[1] | idx_q[0], idx_q[1] & idx_q[0], ~idx_q[1]};
    mism     = y_bus ^ expected;
    mism_cnt = 3'd0;
    for (int i = 0; i < 7; i++) begin
      mism_cnt = mism_cnt + {2'b00, mism[i]};
    end
    err_max  = {3'b000, {ERR_W{1'b1}}};
    err_sum  = {3'b000, err_q} + {{(SW-3){1'b0}}, mism_cnt};
    last_vec = (idx_q == 2'd3) && (pass_cnt_q == PCW'(PASSES - 1));
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    settle_cnt_d = settle_cnt_q;
    pass_cnt_d   = pass_cnt_q;
    err_d        = err_q;
    fail_d       = fail_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_SETTLE;
          idx_d        = 2'b00;
          settle_cnt_d = '0;
          pass_cnt_d   = '0;
          err_d        = '0;
          fail_d       = '0;
        end
      end
      S_SETTLE: begin
        if (settle_cnt_q == SCW'(SETTLE_CYCLES - 1)) begin
          settle_cnt_d = '0;
          state_d      = S_CHECK;
        end else begin
          settle_cnt_d = settle_cnt_q + SCW'(1);
        end
      end
      S_CHECK: begin
        fail_d = fail_q | mism;
        err_d  = (err_sum > err_max) ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
        if (last_vec || (mism != 7'd0)) begin
`else
        if (last_vec) begin
`endif
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = S_SETTLE;
          if (idx_q == 2'd3) begin
            pass_cnt_d = pass_cnt_q + PCW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign A         = idx_q[1];
  assign B         = idx_q[0];
  assign busy      = (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign done      = (state_q == S_DONE);
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;
  assign fail_mask = fail_q;

endmodule
